// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a guard-blanked slot per digit
// and frame-synchronous double buffering of the displayed value.
module seg_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  rom_addr,
  input  logic [6:0]  rom_data,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        load_ack
);

  localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [15:0]     shadow, pend_val;
  logic [3:0]      shadow_dp, pend_dp;
  logic            pend;
  logic [3:0]      an_nxt;
  logic [6:0]      seg_nxt;
  logic            dp_nxt;
  logic            slot_end;
  logic            take;

  assign slot_end = (cnt == CNT_LAST);
  // Commit only at the very last cycle of digit 3 so a frame never mixes values.
  assign take     = slot_end && (idx == 2'd3) && (load || pend);
  assign rom_addr = shadow[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BLANK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    an_nxt    = 4'b1111;
    seg_nxt   = 7'b1111111;
    dp_nxt    = 1'b1;
    case (state)
      BLANK: if (cnt == BLANK_LAST) state_nxt = SHOW;
      SHOW: begin
        an_nxt  = ~(4'b0001 << idx);
        seg_nxt = rom_data;
        dp_nxt  = ~shadow_dp[idx];
      end
      default: state_nxt = BLANK;
    endcase
    if (slot_end) begin
      cnt_nxt   = '0;
      idx_nxt   = idx + 2'd1;
      state_nxt = BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= 2'd0;
      shadow    <= 16'h0000;
      shadow_dp <= 4'b0000;
      pend_val  <= 16'h0000;
      pend_dp   <= 4'b0000;
      pend      <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
      load_ack  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
      dp       <= dp_nxt;
      load_ack <= take;
      // A load arriving on the commit cycle bypasses the pending registers.
      if (take) begin
        shadow    <= load ? value : pend_val;
        shadow_dp <= load ? dp_in : pend_dp;
        pend      <= 1'b0;
      end else if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2 and a small ROM model.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  rom_addr;
  logic [6:0]  rom_data;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        load_ack;

  int checks = 0;
  int fails  = 0;
  int cyc;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .rom_addr(rom_addr), .rom_data(rom_data), .seg(seg), .dp(dp), .an(an),
    .load_ack(load_ack)
  );

  function automatic logic [6:0] rom_f(input logic [3:0] a);
    case (a)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'hA:    return 7'b0001000;
      4'hF:    return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb rom_data = rom_f(rom_addr);

  // Posedges since reset release; outputs seen after edge k reflect scan cycle k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Expected {an, seg, dp} for scan cycle j of a display holding v / d.
  function automatic logic [11:0] exp_out(input logic [15:0] v, input logic [3:0] d, input int j);
    int slot;
    if (j < 0 || (j % 8) < 2) return {4'b1111, 7'b1111111, 1'b1};
    slot = (j / 8) % 4;
    return {~(4'b0001 << slot), rom_f(v[slot*4 +: 4]), ~d[slot]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(~an) > 1) begin
        fails++;
        $display("FAIL an_one_cold cyc=%0d: an=%b, at most one low bit required", cyc, an);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'b1111) begin fails++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (seg !== 7'b1111111) begin fails++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    checks++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b want 1", dp); end
    checks++; if (load_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", load_ack); end
    checks++; if (rom_addr !== 4'h0) begin fails++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [11:0] e;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      e = exp_out(16'h0000, 4'b0000, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL scan cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      checks++;
      if (load_ack !== 1'b0) begin fails++; $display("FAIL scan_ack cyc=%0d: got %b want 0", cyc, load_ack); end
    end
  endtask

  task automatic test_load_midframe();
    logic [11:0] e;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      e = exp_out(16'h0000, 4'b0000, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL midframe_hold cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      checks++;
      if (load_ack !== (cyc == 64)) begin fails++; $display("FAIL midframe_ack cyc=%0d: got %b want %b", cyc, load_ack, cyc == 64); end
      if (cyc == 40) begin load = 1'b1; value = 16'hF1A0; dp_in = 4'b0100; end
      else load = 1'b0;
    end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      e = exp_out(16'hF1A0, 4'b0100, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL midframe_new cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      checks++;
      if (load_ack !== 1'b0) begin fails++; $display("FAIL midframe_ack2 cyc=%0d: got %b want 0", cyc, load_ack); end
      if (cyc == 83) begin
        checks++;
        if ({an, seg, dp} !== {4'b1011, 7'b1111001, 1'b0}) begin
          fails++; $display("FAIL digit2_dp: an/seg/dp=%b/%b/%b want 1011/1111001/0", an, seg, dp);
        end
      end
      if (cyc == 91) begin
        checks++;
        if ({an, seg, dp} !== {4'b0111, 7'b0001110, 1'b1}) begin
          fails++; $display("FAIL digit3_f: an/seg/dp=%b/%b/%b want 0111/0001110/1", an, seg, dp);
        end
      end
    end
  endtask

  task automatic test_two_loads();
    logic [11:0] e;
    int acks = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      e = exp_out(16'hF1A0, 4'b0100, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL two_loads_hold cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (load_ack) acks++;
      if (cyc == 100) begin load = 1'b1; value = 16'h1111; dp_in = 4'b1111; end
      else if (cyc == 110) begin load = 1'b1; value = 16'hAAAA; dp_in = 4'b0000; end
      else load = 1'b0;
    end
    checks++;
    if (acks !== 1) begin fails++; $display("FAIL two_loads_ack_count: got %0d want 1", acks); end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      e = exp_out(16'hAAAA, 4'b0000, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL two_loads_new cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (cyc == 131) begin
        checks++;
        if ({an, seg, dp} !== {4'b1110, 7'b0001000, 1'b1}) begin
          fails++; $display("FAIL last_wins: an/seg/dp=%b/%b/%b want 1110/0001000/1", an, seg, dp);
        end
      end
    end
  endtask

  task automatic test_commit_cycle();
    logic [11:0] e;
    int acks = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      e = exp_out(16'hAAAA, 4'b0000, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL commit_hold cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      checks++;
      if (load_ack !== (cyc == 192)) begin fails++; $display("FAIL commit_ack cyc=%0d: got %b want %b", cyc, load_ack, cyc == 192); end
      if (load_ack) acks++;
      if (cyc == 191) begin load = 1'b1; value = 16'h0F1A; dp_in = 4'b1001; end
      else load = 1'b0;
    end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      e = exp_out(16'h0F1A, 4'b1001, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL commit_new cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (load_ack) acks++;
      if (cyc == 195) begin
        checks++;
        if ({an, seg, dp} !== {4'b1110, 7'b0001000, 1'b0}) begin
          fails++; $display("FAIL commit_digit0: an/seg/dp=%b/%b/%b want 1110/0001000/0", an, seg, dp);
        end
      end
    end
    checks++;
    if (acks !== 1) begin fails++; $display("FAIL commit_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      e = exp_out(16'h0F1A, 4'b1001, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL pre_reset cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      if (cyc == 230) begin load = 1'b1; value = 16'h1111; dp_in = 4'b1111; end
      else load = 1'b0;
    end
    checks++;
    if (an !== 4'b1011) begin fails++; $display("FAIL pre_reset_slot2: an=%b want 1011", an); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'b1111) begin fails++; $display("FAIL async_an: got %b want 1111", an); end
    checks++; if (seg !== 7'b1111111) begin fails++; $display("FAIL async_seg: got %b want 1111111", seg); end
    checks++; if (dp !== 1'b1) begin fails++; $display("FAIL async_dp: got %b want 1", dp); end
    checks++; if (rom_addr !== 4'h0) begin fails++; $display("FAIL async_rom_addr: got %h want 0", rom_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      e = exp_out(16'h0000, 4'b0000, cyc - 1);
      checks++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL post_reset cyc=%0d: an/seg/dp=%b/%b/%b want %b/%b/%b", cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
      checks++;
      if (load_ack !== 1'b0) begin fails++; $display("FAIL post_reset_ack cyc=%0d: got %b want 0", cyc, load_ack); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_two_loads();
    test_commit_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
